// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA framebuffer path.
//   - default active resolution (H_RES_DEF x V_RES_DEF)
//   - coordinate width used by the vga timing generator (COORD_W)
//   - scan-out latency in clock cycles (SCAN_LAT), from draw/x/y to pix_*
//   - arbiter FSM state encoding (arb_state_e)
//   - per-pixel tag carried alongside an in-flight scan access (scan_tag_t)
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int COORD_W   = 10;

    // draw/x/y in cycle N -> pix_data/pix_valid in cycle N+SCAN_LAT.
    // One cycle to register the RAM request, one for the RAM read,
    // one for the output register.
    localparam int SCAN_LAT  = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_HOLD  = 2'd3
    } arb_state_e;

    // What the output stage must do with the slot that belongs to a pixel:
    //   active : pixel is inside active video (drives pix_valid)
    //   rd     : a RAM read was issued, take mem_rdata
    //   reuse  : no read issued, return the held pixel
    // active with neither rd nor reuse means out-of-range -> black pixel.
    typedef struct packed {
        logic active;
        logic rd;
        logic reuse;
    } scan_tag_t;

endpackage

// File: rtl/vga_fb_addr.sv
// ---------------------------------------------------------------------------
// vga_fb_addr
// Converts the scan position (x, y) into a linear framebuffer address:
//     addr = (y >> SCALE) * (H_RES >> SCALE) + (x >> SCALE)
// evaluated at full ADDR_W width, plus a flag telling whether (x, y) lies
// inside the H_RES x V_RES active area. The result is combinational so the
// arbiter can compare it against the last read address in the same cycle;
// the arbiter registers it into mem_addr.
//
// Ports
//   x, y      in   COORD_W  scan position from the vga timing generator
//   addr      out  ADDR_W   framebuffer word address
//   in_range  out  1        x < H_RES and y < V_RES
// ---------------------------------------------------------------------------
module vga_fb_addr
    import vga_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int SCALE  = 1,
    parameter int ADDR_W = 17
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic               in_range
);

    // One extra bit so a limit of 1024 is still representable.
    localparam int                CW1   = COORD_W + 1;
    localparam logic [CW1-1:0]    X_LIM = CW1'(H_RES);
    localparam logic [CW1-1:0]    Y_LIM = CW1'(V_RES);
    localparam int                FB_W  = H_RES >> SCALE;

    logic [COORD_W-1:0] x_fb;
    logic [COORD_W-1:0] y_fb;

    assign x_fb = x >> SCALE;
    assign y_fb = y >> SCALE;

    // Both operands are widened to ADDR_W before the multiply so the
    // product is never truncated to the coordinate width.
    assign addr     = ADDR_W'(y_fb) * ADDR_W'(FB_W) + ADDR_W'(x_fb);
    assign in_range = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);

endmodule

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
// Owns the single port of a synchronous framebuffer RAM and shares it
// between the scan-out reader (driven by the vga timing generator) and a
// pixel-write client. Scan reads always win; a write is granted only in a
// cycle where the scanner does not need the RAM, and never in two
// consecutive cycles.
//
// Optional feature, macro VGA_ARB_REUSE_EN:
//   with SCALE > 0 neighbouring pixels map to the same framebuffer word.
//   The last read address is remembered and a repeated address is served
//   from a held copy of the pixel, freeing the RAM slot for the writer.
//   The held copy is invalidated when draw drops, on reset and whenever
//   the client writes that address. Without the macro every in-range draw
//   cycle issues a RAM read.
//
// Ports
//   clk        in   1       pixel clock (same as vga)
//   rst        in   1       asynchronous reset, active low
//   draw       in   1       active-video flag from vga
//   x, y       in   10      scan position from vga
//   wr_req     in   1       write request, held until wr_ack
//   wr_addr    in   ADDR_W  write address
//   wr_data    in   PIX_W   write data
//   wr_ack     out  1       one-cycle pulse, coincides with mem_we
//   mem_en     out  1       RAM enable
//   mem_we     out  1       RAM write enable
//   mem_addr   out  ADDR_W  RAM address
//   mem_wdata  out  PIX_W   RAM write data
//   mem_rdata  in   PIX_W   RAM read data, one cycle after mem_en
//   pix_data   out  PIX_W   scan-out pixel, SCAN_LAT cycles after draw/x/y
//   pix_valid  out  1       pix_data belongs to an active-video pixel
// ---------------------------------------------------------------------------
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int SCALE  = 1,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               draw,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               wr_req,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIX_W-1:0]   wr_data,
    output logic               wr_ack,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [PIX_W-1:0]   mem_wdata,
    input  logic [PIX_W-1:0]   mem_rdata,
    output logic [PIX_W-1:0]   pix_data,
    output logic               pix_valid
);

    // Tag stages between the request cycle and the output register.
    localparam int TAG_STAGES = SCAN_LAT - 1;

    // ------------------------------------------------------------------
    // Scan address
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_in_range;

    vga_fb_addr #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .SCALE  (SCALE),
        .ADDR_W (ADDR_W)
    ) u_fb_addr (
        .x        (x),
        .y        (y),
        .addr     (scan_addr),
        .in_range (scan_in_range)
    );

    // ------------------------------------------------------------------
    // Read decision
    // ------------------------------------------------------------------
    logic            need_read;
    logic            scan_rd;
    logic            reuse_hit;
    logic            wr_grant;
    logic [PIX_W-1:0] held_pix;
    arb_state_e      state_q;
    arb_state_e      state_d;
    scan_tag_t       tag_q [TAG_STAGES];
    scan_tag_t       tag_d;
    scan_tag_t       tag_last;

    assign tag_last = tag_q[TAG_STAGES-1];

`ifdef VGA_ARB_REUSE_EN
    logic [ADDR_W-1:0] last_addr_q;
    logic              last_valid_q;
    logic [PIX_W-1:0]  held_pix_q;

    always_comb begin
        need_read = 1'b1;
        if ((SCALE > 0) && last_valid_q && (scan_addr == last_addr_q)) begin
            need_read = 1'b0;
        end
    end

    // Last-read tracking. A write granted this cycle to the held address
    // executes next cycle, so clearing the flag now forces the next pixel
    // at that address to be fetched after the write has landed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
            held_pix_q   <= '0;
        end else begin
            if (!draw) begin
                last_valid_q <= 1'b0;
            end else if (scan_rd) begin
                last_addr_q  <= scan_addr;
                last_valid_q <= 1'b1;
            end else if (wr_grant && (wr_addr == last_addr_q)) begin
                last_valid_q <= 1'b0;
            end

            if (tag_last.rd) begin
                held_pix_q <= mem_rdata;
            end
        end
    end

    assign held_pix = held_pix_q;
`else
    assign need_read = 1'b1;
    assign held_pix  = '0;
`endif

    // Out-of-range draw cycles never touch the RAM.
    assign scan_rd   = draw & scan_in_range & need_read;
    assign reuse_hit = draw & scan_in_range & ~need_read;

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    // A read that lands right after a write goes through S_HOLD instead of
    // S_READ; both issue a read, the distinction only records that the
    // cycle after a write was taken by the scanner.
    always_comb begin
        state_d = S_IDLE;
        if (scan_rd) begin
            state_d = (state_q == S_WRITE) ? S_HOLD : S_READ;
        end else if (wr_req && (state_q != S_WRITE)) begin
            // Blocking a grant while in S_WRITE ignores wr_req during the
            // ack cycle, so one request yields one write at most every
            // other cycle.
            state_d = S_WRITE;
        end
    end

    assign wr_grant = (state_d == S_WRITE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // RAM-side output registers
    // ------------------------------------------------------------------
    logic               mem_en_q;
    logic               mem_we_q;
    logic               wr_ack_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [PIX_W-1:0]   mem_wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= (state_d != S_IDLE);
            mem_we_q <= wr_grant;
            wr_ack_q <= wr_grant;
            if (wr_grant) begin
                mem_addr_q  <= wr_addr;
                mem_wdata_q <= wr_data;
            end else if (scan_rd) begin
                mem_addr_q  <= scan_addr;
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign wr_ack    = wr_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // ------------------------------------------------------------------
    // Scan tag pipeline: follows each pixel until its data is available
    // ------------------------------------------------------------------
    assign tag_d = '{active: draw, rd: scan_rd, reuse: reuse_hit};

    generate
        for (genvar gi = 0; gi < TAG_STAGES; gi++) begin : g_tag
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        tag_q[gi] <= '0;
                    end else begin
                        tag_q[gi] <= tag_d;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        tag_q[gi] <= '0;
                    end else begin
                        tag_q[gi] <= tag_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pixel output register
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] pix_data_d;
    logic [PIX_W-1:0] pix_data_q;
    logic             pix_valid_q;

    // rd and reuse are only ever set together with active, so blanking and
    // out-of-range pixels both fall through to black.
    always_comb begin
        pix_data_d = '0;
        if (tag_last.rd) begin
            pix_data_d = mem_rdata;
        end else if (tag_last.reuse) begin
            pix_data_d = held_pix;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            pix_data_q  <= pix_data_d;
            pix_valid_q <= tag_last.active;
        end
    end

    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_arbiter
// Directed bench for vga_fb_arbiter (H_RES=640, V_RES=480, SCALE=1,
// PIX_W=8, ADDR_W=17) with a behavioural single-port synchronous RAM.
// Inputs change 1 time unit after a rising edge; outputs are sampled at
// the same point, i.e. after the edge that registered them. Sections that
// exercise the held-pixel feature are built only with VGA_ARB_REUSE_EN.
// ---------------------------------------------------------------------------
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        draw = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        wr_req = 1'b0;
    logic [16:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ack;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  pix_data;
    logic        pix_valid;

    int total = 0;
    int bad   = 0;

    vga_fb_arbiter #(
        .H_RES  (640),
        .V_RES  (480),
        .SCALE  (1),
        .PIX_W  (8),
        .ADDR_W (17)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .draw      (draw),
        .x         (x),
        .y         (y),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pix_data  (pix_data),
        .pix_valid (pix_valid)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM: read data one cycle after mem_en.
    logic [7:0]  ram [0:131071];
    int unsigned write_count = 0;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                write_count   <= write_count + 1;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Client-side write used to preload the RAM through the arbiter.
    task automatic do_write(input logic [16:0] a, input logic [7:0] d);
        logic got;
        got     = 1'b0;
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            if (wr_ack) got = 1'b1;
        end
        wr_req = 1'b0;
        check("preload_ack", 32'(got), 32'd1);
    endtask

    initial begin
        int unsigned wc0;

        // ---------------- reset ----------------
        rst = 1'b0;
        repeat (3) step();
        check("rst_mem_en",    32'(mem_en),    32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_wr_ack",    32'(wr_ack),    32'd0);
        check("rst_pix_data",  32'(pix_data),  32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        rst = 1'b1;
        step();
        step();
        check("rel_mem_en",    32'(mem_en),    32'd0);
        check("rel_mem_we",    32'(mem_we),    32'd0);
        check("rel_wr_ack",    32'(wr_ack),    32'd0);
        check("rel_pix_valid", 32'(pix_valid), 32'd0);

        // ---------------- preload through the write port ----------------
        do_write(17'd641,   8'h5A);
        do_write(17'd76799, 8'hC3);
        do_write(17'd0,     8'hA0);
        do_write(17'd1,     8'hA1);
        do_write(17'd2,     8'hA2);
        do_write(17'd3,     8'hA3);
        do_write(17'd4,     8'hB0);
        step();
        step();

        // ---------------- single scan read: x=2, y=4 -> 2*320+1 ----------------
        draw = 1'b1; x = 10'd2; y = 10'd4;
        step();                                     // N+1
        draw = 1'b0;
        check("scan_mem_en",   32'(mem_en),   32'd1);
        check("scan_mem_we",   32'(mem_we),   32'd0);
        check("scan_mem_addr", 32'(mem_addr), 32'd641);
        step();                                     // N+2
        check("scan_n2_valid", 32'(pix_valid), 32'd0);
        step();                                     // N+3
        check("scan_pix_data",  32'(pix_data),  32'h5A);
        check("scan_pix_valid", 32'(pix_valid), 32'd1);
        step();                                     // N+4
        check("scan_n4_valid", 32'(pix_valid), 32'd0);

        // ---------------- last in-range pixel ----------------
        draw = 1'b1; x = 10'd639; y = 10'd479;
        step();
        draw = 1'b0;
        check("last_mem_addr", 32'(mem_addr), 32'd76799);
        step();
        step();
        check("last_pix_data",  32'(pix_data),  32'hC3);
        check("last_pix_valid", 32'(pix_valid), 32'd1);

        // ---------------- out of range: x = H_RES ----------------
        draw = 1'b1; x = 10'd640; y = 10'd0;
        step();
        draw = 1'b0;
        check("oorx_mem_en", 32'(mem_en), 32'd0);
        step();
        step();
        check("oorx_pix_data",  32'(pix_data),  32'd0);
        check("oorx_pix_valid", 32'(pix_valid), 32'd1);

        // ---------------- out of range: y = V_RES ----------------
        draw = 1'b1; x = 10'd0; y = 10'd480;
        step();
        draw = 1'b0;
        check("oory_mem_en", 32'(mem_en), 32'd0);
        step();
        step();
        check("oory_pix_data",  32'(pix_data),  32'd0);
        check("oory_pix_valid", 32'(pix_valid), 32'd1);
        step();

        // ---------------- write held off during an active line ----------------
        // x steps by 2 so every pixel is a new framebuffer word.
        wr_req = 1'b1; wr_addr = 17'd100; wr_data = 8'h77;
        draw = 1'b1; y = 10'd6;
        for (int i = 0; i < 6; i++) begin
            x = 10'(20 + 2 * i);
            step();
            check("line_no_ack", 32'(wr_ack), 32'd0);
            check("line_rd_en",  32'(mem_en), 32'd1);
            check("line_rd_we",  32'(mem_we), 32'd0);
        end
        draw = 1'b0;
        step();
        check("hb_wr_ack",    32'(wr_ack),    32'd1);
        check("hb_mem_we",    32'(mem_we),    32'd1);
        check("hb_mem_addr",  32'(mem_addr),  32'd100);
        check("hb_mem_wdata", 32'(mem_wdata), 32'h77);
        wr_req = 1'b0;
        step();
        check("hb_ack_pulse", 32'(wr_ack), 32'd0);
        check("hb_ram_data",  32'(ram[100]), 32'h77);

        // ---------------- back-to-back writes in blanking ----------------
        wc0 = write_count;
        wr_req = 1'b1; wr_addr = 17'd200; wr_data = 8'h11;
        step();
        check("b2b_ack1",  32'(wr_ack),   32'd1);
        check("b2b_addr1", 32'(mem_addr), 32'd200);
        wr_addr = 17'd201; wr_data = 8'h22;
        step();
        check("b2b_gap",   32'(wr_ack),   32'd0);
        step();
        check("b2b_ack2",   32'(wr_ack),    32'd1);
        check("b2b_addr2",  32'(mem_addr),  32'd201);
        check("b2b_wdata2", 32'(mem_wdata), 32'h22);
        wr_req = 1'b0;
        step();
        check("b2b_after", 32'(wr_ack), 32'd0);
        step();
        check("b2b_count", write_count - wc0, 32'd2);

`ifdef VGA_ARB_REUSE_EN
        // ---------------- held-pixel reuse over x = 0..7 ----------------
        begin : reuse_blk
            int reads;
            int acks;
            reads = 0;
            acks  = 0;
            y = 10'd0; wr_req = 1'b1; wr_addr = 17'd1000; wr_data = 8'h40;
            for (int i = 0; i < 10; i++) begin
                x      = 10'(i);
                draw   = (i < 8);
                if (i >= 8) wr_req = 1'b0;
                step();
                if (i < 8) begin
                    if ((i % 2) == 0) begin
                        check("reuse_rd_en",   32'(mem_en),   32'd1);
                        check("reuse_rd_addr", 32'(mem_addr), 32'(i / 2));
                    end else begin
                        check("reuse_wr_ack", 32'(wr_ack), 32'd1);
                    end
                end
                if (mem_en && !mem_we) reads++;
                if (wr_ack) begin
                    acks++;
                    wr_addr = wr_addr + 17'd1;
                    wr_data = wr_data + 8'd1;
                end
                if (i >= 2) begin
                    check("reuse_pix_data",  32'(pix_data),  32'(8'hA0 + 8'((i - 2) / 2)));
                    check("reuse_pix_valid", 32'(pix_valid), 32'd1);
                end
            end
            check("reuse_reads", 32'(reads), 32'd4);
            check("reuse_acks",  32'(acks),  32'd4);
        end

        // ---------------- write to held address forces a re-read ----------------
        draw = 1'b1; y = 10'd0; x = 10'd8; wr_req = 1'b0;
        step();
        check("coh_rd_addr", 32'(mem_addr), 32'd4);
        x = 10'd9; wr_req = 1'b1; wr_addr = 17'd4; wr_data = 8'hB5;
        step();
        check("coh_wr_ack", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        x = 10'd9; y = 10'd1;
        step();
        check("coh_reread_en",   32'(mem_en),   32'd1);
        check("coh_reread_we",   32'(mem_we),   32'd0);
        check("coh_reread_addr", 32'(mem_addr), 32'd4);
        check("coh_pix0", 32'(pix_data), 32'hB0);
        draw = 1'b0;
        step();
        check("coh_pix1", 32'(pix_data), 32'hB0);
        step();
        check("coh_pix2", 32'(pix_data), 32'hB5);
        step();
        step();
`endif

        // ---------------- reset with a write pending and a read in flight ----------------
        wc0 = write_count;
        draw = 1'b1; x = 10'd10; y = 10'd10;
        wr_req = 1'b1; wr_addr = 17'd300; wr_data = 8'h33;
        step();
        check("rmid_pre_en", 32'(mem_en), 32'd1);
        rst = 1'b0;
        #1;
        check("rmid_mem_en",    32'(mem_en),    32'd0);
        check("rmid_mem_addr",  32'(mem_addr),  32'd0);
        check("rmid_wr_ack",    32'(wr_ack),    32'd0);
        check("rmid_pix_valid", 32'(pix_valid), 32'd0);
        draw = 1'b0;
        step();
        step();
        check("rmid_hold_ack", 32'(wr_ack), 32'd0);
        rst = 1'b1;
        wr_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rmid_post_valid", 32'(pix_valid), 32'd0);
            check("rmid_post_ack",   32'(wr_ack),    32'd0);
        end
        check("rmid_no_write", write_count - wc0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
